// File: rtl/csi_mag_averager.sv
// Per-subcarrier averager over 2**LOG2_AVG CSI frames, drained as a valid/ready vector stream.
// Optional drop counter port drop_count_out is enabled by defining CSI_AVG_DROP_CNT_EN.
module csi_mag_averager #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SC     = 64,
    parameter int LOG2_AVG   = 3
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [DATA_WIDTH-1:0]     mag_in,
    input  logic                      mag_valid_in,
    input  logic                      sof_in,
    output logic [DATA_WIDTH-1:0]     avg_out,
    output logic [$clog2(NUM_SC)-1:0] avg_idx_out,
    output logic                      avg_valid_out,
    output logic                      avg_last_out,
`ifdef CSI_AVG_DROP_CNT_EN
    output logic [15:0]               drop_count_out,
`endif
    input  logic                      avg_ready_in
);

    localparam int ACC_W = DATA_WIDTH + LOG2_AVG;
    localparam int IDX_W = $clog2(NUM_SC);
    localparam int FC_W  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SC - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'((1 << LOG2_AVG) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] sc_idx_reg, sc_idx_next;
    logic [FC_W-1:0]  frame_cnt_reg, frame_cnt_next;

    logic             wr_en;
    logic             wr_first;
    logic [IDX_W-1:0] wr_addr;
    logic [ACC_W-1:0] wr_data;
    logic [ACC_W-1:0] rd_reg;
    logic [ACC_W-1:0] acc_mem [NUM_SC];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            sc_idx_reg    <= '0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sc_idx_reg    <= sc_idx_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sc_idx_next    = sc_idx_reg;
        frame_cnt_next = frame_cnt_reg;
        wr_en          = 1'b0;
        wr_first       = 1'b0;
        wr_addr        = sc_idx_reg;
        case (state_reg)
            IDLE: begin
                if (mag_valid_in && sof_in) begin
                    wr_en       = 1'b1;
                    wr_first    = (frame_cnt_reg == '0);
                    wr_addr     = '0;
                    sc_idx_next = IDX_W'(1);
                    state_next  = ACCUM;
                end
            end
            ACCUM: begin
                if (mag_valid_in) begin
                    wr_en = 1'b1;
                    if (sof_in) begin
                        // Short frame: restart the whole window from this sample
                        wr_first       = 1'b1;
                        wr_addr        = '0;
                        frame_cnt_next = '0;
                        sc_idx_next    = IDX_W'(1);
                    end else begin
                        wr_first = (frame_cnt_reg == '0);
                        if (sc_idx_reg == LAST_IDX) begin
                            sc_idx_next = '0;
                            if (frame_cnt_reg == FC_MAX) begin
                                frame_cnt_next = '0;
                                state_next     = DRAIN;
                            end else begin
                                frame_cnt_next = frame_cnt_reg + FC_W'(1);
                                state_next     = IDLE;
                            end
                        end else begin
                            sc_idx_next = sc_idx_reg + IDX_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (avg_ready_in) begin
                    if (sc_idx_reg == LAST_IDX) begin
                        sc_idx_next    = '0;
                        frame_cnt_next = '0;
                        state_next     = IDLE;
                    end else begin
                        sc_idx_next = sc_idx_reg + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_data = wr_first ? ACC_W'(mag_in) : (rd_reg + ACC_W'(mag_in));

    // Read address is the next index, so rd_reg always holds acc[sc_idx_reg]:
    // the pre-fetched operand for accumulation, or the current beat while draining.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            acc_mem[wr_addr] <= wr_data;
        end
        rd_reg <= acc_mem[sc_idx_next];
    end

    assign avg_valid_out = (state_reg == DRAIN);
    assign avg_idx_out   = avg_valid_out ? sc_idx_reg : '0;
    assign avg_last_out  = avg_valid_out && (sc_idx_reg == LAST_IDX);
    assign avg_out       = avg_valid_out ? DATA_WIDTH'(rd_reg >> LOG2_AVG) : '0;

`ifdef CSI_AVG_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;
    logic        drop_inc;

    // Any sof outside IDLE discards a frame: an aborted window in ACCUM or a frame dropped in DRAIN
    assign drop_inc = mag_valid_in && sof_in && (state_reg != IDLE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            drop_cnt_reg <= '0;
        end else if (drop_inc && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_count_out = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_csi_mag_averager.sv
// Directed bench for csi_mag_averager: one instance averaging 2 frames, one in pass-through.
module tb_csi_mag_averager;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mag_in;
    logic        sof_in;
    logic        valid;
    logic        valid0;
    logic        ready;
    logic        ready0;

    logic [31:0] avg;
    logic [1:0]  idx;
    logic        avg_valid;
    logic        last;
    logic [31:0] avg0;
    logic [1:0]  idx0;
    logic        avg_valid0;
    logic        last0;
`ifdef CSI_AVG_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] drop_cnt0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    csi_mag_averager #(.DATA_WIDTH(32), .NUM_SC(4), .LOG2_AVG(1)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .mag_in        (mag_in),
        .mag_valid_in  (valid),
        .sof_in        (sof_in),
        .avg_out       (avg),
        .avg_idx_out   (idx),
        .avg_valid_out (avg_valid),
        .avg_last_out  (last),
`ifdef CSI_AVG_DROP_CNT_EN
        .drop_count_out(drop_cnt),
`endif
        .avg_ready_in  (ready)
    );

    csi_mag_averager #(.DATA_WIDTH(32), .NUM_SC(4), .LOG2_AVG(0)) dut0 (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .mag_in        (mag_in),
        .mag_valid_in  (valid0),
        .sof_in        (sof_in),
        .avg_out       (avg0),
        .avg_idx_out   (idx0),
        .avg_valid_out (avg_valid0),
        .avg_last_out  (last0),
`ifdef CSI_AVG_DROP_CNT_EN
        .drop_count_out(drop_cnt0),
`endif
        .avg_ready_in  (ready0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample on the selected instance; returns 1 time unit after the accepting edge
    task automatic send(input bit to0, input bit s, input logic [31:0] m);
        mag_in = m;
        sof_in = s;
        if (to0) valid0 = 1'b1;
        else     valid  = 1'b1;
        @(posedge clk_in);
        #1;
        valid  = 1'b0;
        valid0 = 1'b0;
        sof_in = 1'b0;
    endtask

    task automatic send_frame(input bit to0, input logic [31:0] a, b, c, d);
        send(to0, 1'b1, a);
        send(to0, 1'b0, b);
        send(to0, 1'b0, c);
        send(to0, 1'b0, d);
    endtask

    // Collects four beats, optionally with ready alternating 0/1, checking each visible beat
    task automatic drain(input bit use0, input logic [31:0] e0, e1, e2, e3, input bit toggle);
        logic [31:0] exp_v [4];
        int beat;
        int cyc;
        bit rdy;
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        beat = 0;
        cyc  = 0;
        while (beat < 4 && cyc < 40) begin
            rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            if (use0) ready0 = rdy;
            else      ready  = rdy;
            if (use0 ? avg_valid0 : avg_valid) begin
                check("beat_data", use0 ? avg0 : avg, exp_v[beat]);
                check("beat_idx", 32'(use0 ? idx0 : idx), 32'(beat));
                check("beat_last", 32'(use0 ? last0 : last), 32'(beat == 3));
                if (rdy) beat++;
            end
            @(posedge clk_in);
            #1;
            cyc++;
        end
        check("drain_beats", 32'(beat), 32'd4);
        check("valid_after_drain", 32'(use0 ? avg_valid0 : avg_valid), 32'd0);
        ready  = 1'b1;
        ready0 = 1'b1;
    endtask

    // Reset pulse between clock edges; outputs must clear before any edge
    task automatic rst_pulse();
        #2;
        rst_in = 1'b1;
        #1;
        check("async_rst_valid", 32'(avg_valid), 32'd0);
        check("async_rst_data", avg, 32'd0);
        check("async_rst_last", 32'(last), 32'd0);
`ifdef CSI_AVG_DROP_CNT_EN
        check("async_rst_drop", 32'(drop_cnt), 32'd0);
`endif
        #2;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b1;
        mag_in = '0;
        sof_in = 1'b0;
        valid  = 1'b0;
        valid0 = 1'b0;
        ready  = 1'b1;
        ready0 = 1'b1;
        #3;
        check("reset_valid", 32'(avg_valid), 32'd0);
        check("reset_data", avg, 32'd0);
        check("reset_idx", 32'(idx), 32'd0);
        check("reset_last", 32'(last), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // Two clean frames, ready held high
        send_frame(0, 10, 20, 30, 40);
        check("idle_between_frames", 32'(avg_valid), 32'd0);
        send_frame(0, 12, 22, 32, 42);
        check("latency_valid", 32'(avg_valid), 32'd1);
        drain(0, 11, 21, 31, 41, 0);
        $display("txn basic window done");

        // Same window, ready toggling
        send_frame(0, 10, 20, 30, 40);
        send_frame(0, 12, 22, 32, 42);
        drain(0, 11, 21, 31, 41, 1);
        $display("txn backpressure window done");

        // Short frame aborted by a new sof
        send(0, 1'b1, 10);
        send(0, 1'b0, 20);
        send_frame(0, 100, 100, 100, 100);
        send_frame(0, 200, 200, 200, 200);
        drain(0, 150, 150, 150, 150, 0);
`ifdef CSI_AVG_DROP_CNT_EN
        check("drop_after_short", 32'(drop_cnt), 32'd1);
`endif
        $display("txn short frame window done");

        // Over-long frame: samples 5 and 6 must be ignored
        send_frame(0, 20, 40, 60, 80);
        send(0, 1'b0, 500);
        send(0, 1'b0, 600);
        send_frame(0, 40, 60, 80, 100);
        drain(0, 30, 50, 70, 90, 0);
        $display("txn long frame window done");

        // Frame arriving during DRAIN is dropped
        send_frame(0, 10, 20, 30, 40);
        send_frame(0, 12, 22, 32, 42);
        ready = 1'b0;
        send_frame(0, 5, 5, 5, 5);
        check("drain_hold_data", avg, 32'd11);
        check("drain_hold_idx", 32'(idx), 32'd0);
        drain(0, 11, 21, 31, 41, 0);
        send_frame(0, 2, 4, 6, 8);
        send_frame(0, 4, 6, 8, 10);
        drain(0, 3, 5, 7, 9, 0);
`ifdef CSI_AVG_DROP_CNT_EN
        check("drop_after_drain_sof", 32'(drop_cnt), 32'd2);
`endif
        $display("txn drop during drain done");

        // Async reset mid-DRAIN, then mid-ACCUM, then a fresh window
        send_frame(0, 99, 99, 99, 99);
        send_frame(0, 99, 99, 99, 99);
        check("pre_rst_valid", 32'(avg_valid), 32'd1);
        rst_pulse();
        send_frame(0, 99, 99, 99, 99);
        send(0, 1'b1, 99);
        send(0, 1'b0, 99);
        rst_pulse();
        send_frame(0, 1, 3, 5, 7);
        send_frame(0, 3, 5, 7, 9);
        drain(0, 2, 4, 6, 8, 0);
        $display("txn reset recovery done");

        // Pass-through instance
        send_frame(1, 7, 8, 9, 10);
        check("pass_latency", 32'(avg_valid0), 32'd1);
        drain(1, 7, 8, 9, 10, 0);
        $display("txn pass-through done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
